// File: rtl/painterengine_gpu_dma_reader_mc.sv
// Multi-channel AXI4 read DMA: one routed consumer per transfer, 4 KB-safe bursts,
// RLAST/RRESP checking and a handshake watchdog with a sticky error state.
module painterengine_gpu_dma_reader_mc #(
  parameter int unsigned CH        = 4,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 256,
  parameter int unsigned TO_W      = 19
) (
  input  logic              i_wire_clock,
  input  logic              i_wire_resetn,
  input  logic              i_wire_start,
  input  logic              i_wire_clear,
  input  logic [CH-1:0]     i_wire_router,
  input  logic [CH*32-1:0]  i_wire_address,
  input  logic [CH*32-1:0]  i_wire_length,
  output logic [CH*DW-1:0]  o_wire_data,
  output logic [CH-1:0]     o_wire_data_valid,
  input  logic [CH-1:0]     i_wire_data_next,
  output logic              o_wire_busy,
  output logic              o_wire_done,
  output logic              o_wire_error,
  output logic [2:0]        o_wire_error_type,
  output logic              o_wire_M_AXI_ARID,
  output logic [31:0]       o_wire_M_AXI_ARADDR,
  output logic [7:0]        o_wire_M_AXI_ARLEN,
  output logic [2:0]        o_wire_M_AXI_ARSIZE,
  output logic [1:0]        o_wire_M_AXI_ARBURST,
  output logic              o_wire_M_AXI_ARLOCK,
  output logic [3:0]        o_wire_M_AXI_ARCACHE,
  output logic [2:0]        o_wire_M_AXI_ARPROT,
  output logic [3:0]        o_wire_M_AXI_ARQOS,
  output logic              o_wire_M_AXI_ARVALID,
  input  logic              i_wire_M_AXI_ARREADY,
  input  logic              i_wire_M_AXI_RID,
  input  logic [DW-1:0]     i_wire_M_AXI_RDATA,
  input  logic [1:0]        i_wire_M_AXI_RRESP,
  input  logic              i_wire_M_AXI_RLAST,
  input  logic              i_wire_M_AXI_RVALID,
  output logic              o_wire_M_AXI_RREADY
);

  localparam int unsigned AL = $clog2(DW / 8);
  localparam logic [31:0] MB = 32'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_CALC, S_ADDR, S_DATA, S_DONE, S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [CH-1:0]   sel_q, sel_d;
  logic [31:0]     addr_q, addr_d, len_q, len_d, offset_q, offset_d, araddr_q, araddr_d;
  logic [8:0]      burst_q, burst_d, cnt_q, cnt_d;
  logic [TO_W-1:0] wd_q, wd_d, wd_inc;
  logic [2:0]      err_q, err_d;

  logic [3:0]      sel_cnt;
  logic [31:0]     sel_addr, sel_len;
  logic [31:0]     cur_addr, remain, burst_w;
  logic [12:0]     bytes_4k, beats_4k;
  logic [8:0]      burst_c;
  logic [32:0]     offset_sum;
  logic            in_data, beat, last_beat;
  logic            unused_rid;

  assign unused_rid = i_wire_M_AXI_RID;

  // Router decode: count set bits and pick the selected channel's parameters
  always_comb begin
    sel_cnt  = '0;
    sel_addr = '0;
    sel_len  = '0;
    for (int i = 0; i < int'(CH); i++) begin
      if (i_wire_router[i]) begin
        sel_cnt  = sel_cnt + 4'd1;
        sel_addr = i_wire_address[i*32 +: 32];
        sel_len  = i_wire_length[i*32 +: 32];
      end
    end
  end

  // Burst size: min of MAX_BURST, remaining beats and beats to the next 4 KB page
  always_comb begin
    cur_addr = addr_q + (offset_q << AL);
    remain   = len_q - offset_q;
    bytes_4k = 13'h1000 - {1'b0, cur_addr[11:0]};
    beats_4k = bytes_4k >> AL;
    burst_w  = MB;
    if (remain < burst_w) burst_w = remain;
    if ({19'd0, beats_4k} < burst_w) burst_w = {19'd0, beats_4k};
    burst_c  = burst_w[8:0];
  end

  assign in_data    = (state_q == S_DATA);
  assign beat       = i_wire_M_AXI_RVALID && o_wire_M_AXI_RREADY;
  assign last_beat  = (cnt_q == burst_q - 9'd1);
  assign offset_sum = {1'b0, offset_q} + 33'(burst_q);
  assign wd_inc     = wd_q + TO_W'(1);

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    len_d    = len_q;
    offset_d = offset_q;
    araddr_d = araddr_q;
    burst_d  = burst_q;
    cnt_d    = cnt_q;
    wd_d     = wd_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_wire_start) begin
          sel_d  = i_wire_router;
          addr_d = sel_addr;
          len_d  = sel_len;
          if (sel_cnt == 4'd1) begin
            state_d = S_CHECK;
          end else begin
            err_d   = 3'b001;
            state_d = S_ERROR;
          end
        end
      end
      S_CHECK: begin
        if ((addr_q[AL-1:0] != '0) || (len_q == '0)) begin
          err_d   = 3'b010;
          state_d = S_ERROR;
        end else begin
          offset_d = '0;
          wd_d     = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        araddr_d = cur_addr;
        burst_d  = burst_c;
        cnt_d    = '0;
        state_d  = S_ADDR;
      end
      S_ADDR: begin
        // A handshake wins over a watchdog expiry in the same cycle
        if (i_wire_M_AXI_ARREADY) begin
          wd_d    = '0;
          state_d = S_DATA;
        end else if (wd_inc[TO_W-1]) begin
          err_d   = 3'b011;
          state_d = S_ERROR;
        end else begin
          wd_d = wd_inc;
        end
      end
      S_DATA: begin
        if (beat) begin
          wd_d = '0;
          if (i_wire_M_AXI_RRESP != 2'b00) begin
            err_d   = 3'b110;
            state_d = S_ERROR;
          end else if (i_wire_M_AXI_RLAST != last_beat) begin
            err_d   = 3'b101;
            state_d = S_ERROR;
          end else if (last_beat) begin
            offset_d = offset_sum[31:0];
            cnt_d    = '0;
            state_d  = (offset_sum >= {1'b0, len_q}) ? S_DONE : S_CALC;
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end else if (wd_inc[TO_W-1]) begin
          err_d   = 3'b100;
          state_d = S_ERROR;
        end else begin
          wd_d = wd_inc;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        if (i_wire_clear) begin
          err_d   = 3'b000;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      sel_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      offset_q <= '0;
      araddr_q <= '0;
      burst_q  <= '0;
      cnt_q    <= '0;
      wd_q     <= '0;
      err_q    <= '0;
    end else begin
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      offset_q <= offset_d;
      araddr_q <= araddr_d;
      burst_q  <= burst_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      err_q    <= err_d;
    end
  end

  assign o_wire_busy       = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign o_wire_done       = (state_q == S_DONE);
  assign o_wire_error      = (state_q == S_ERROR);
  assign o_wire_error_type = err_q;

  assign o_wire_M_AXI_ARID    = 1'b0;
  assign o_wire_M_AXI_ARADDR  = araddr_q;
  assign o_wire_M_AXI_ARLEN   = 8'(burst_q - 9'd1);
  assign o_wire_M_AXI_ARSIZE  = 3'(AL);
  assign o_wire_M_AXI_ARBURST = 2'b01;
  assign o_wire_M_AXI_ARLOCK  = 1'b0;
  assign o_wire_M_AXI_ARCACHE = 4'b0010;
  assign o_wire_M_AXI_ARPROT  = 3'b000;
  assign o_wire_M_AXI_ARQOS   = 4'b0000;
  assign o_wire_M_AXI_ARVALID = (state_q == S_ADDR);
  assign o_wire_M_AXI_RREADY  = in_data && |(i_wire_data_next & sel_q);

  // Only the routed channel sees R-channel traffic, and only while in DATA
  for (genvar c = 0; c < int'(CH); c++) begin : g_ch
    assign o_wire_data[c*DW +: DW] = (in_data && sel_q[c]) ? i_wire_M_AXI_RDATA : '0;
    assign o_wire_data_valid[c]    = in_data && sel_q[c] && i_wire_M_AXI_RVALID;
  end

endmodule

// File: tb/tb_painterengine_gpu_dma_reader_mc.sv
// Directed bench for the multi-channel read DMA with a small AXI read slave
// whose beat data equals the beat byte address.
module tb_painterengine_gpu_dma_reader_mc;
  localparam int unsigned CH = 4, DW = 32, MB = 256, TO_W = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic              start, clear;
  logic [CH-1:0]     router, data_next, next_v, tog_v;
  logic [CH*32-1:0]  address, length;
  logic [CH*DW-1:0]  data;
  logic [CH-1:0]     valid;
  logic              busy, done, error;
  logic [2:0]        etype;
  logic              arid, arlock, arvalid, arready;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize, arprot;
  logic [1:0]        arburst, rresp;
  logic [3:0]        arcache, arqos;
  logic              rid, rlast, rvalid, rready;
  logic [DW-1:0]     rdata;
  bit                toggle_en;
  bit                arready_en;
  int                inj_rlast, inj_resp, exp_ch;

  painterengine_gpu_dma_reader_mc #(.CH(CH), .DW(DW), .MAX_BURST(MB), .TO_W(TO_W)) dut (
    .i_wire_clock(clk), .i_wire_resetn(rstn), .i_wire_start(start), .i_wire_clear(clear),
    .i_wire_router(router), .i_wire_address(address), .i_wire_length(length),
    .o_wire_data(data), .o_wire_data_valid(valid), .i_wire_data_next(data_next),
    .o_wire_busy(busy), .o_wire_done(done), .o_wire_error(error), .o_wire_error_type(etype),
    .o_wire_M_AXI_ARID(arid), .o_wire_M_AXI_ARADDR(araddr), .o_wire_M_AXI_ARLEN(arlen),
    .o_wire_M_AXI_ARSIZE(arsize), .o_wire_M_AXI_ARBURST(arburst), .o_wire_M_AXI_ARLOCK(arlock),
    .o_wire_M_AXI_ARCACHE(arcache), .o_wire_M_AXI_ARPROT(arprot), .o_wire_M_AXI_ARQOS(arqos),
    .o_wire_M_AXI_ARVALID(arvalid), .i_wire_M_AXI_ARREADY(arready),
    .i_wire_M_AXI_RID(rid), .i_wire_M_AXI_RDATA(rdata), .i_wire_M_AXI_RRESP(rresp),
    .i_wire_M_AXI_RLAST(rlast), .i_wire_M_AXI_RVALID(rvalid), .o_wire_M_AXI_RREADY(rready)
  );

  assign data_next = toggle_en ? tog_v : next_v;
  always @(negedge clk) tog_v <= CH'($urandom);

  // AXI read slave: one outstanding burst, data = byte address of the beat
  logic        s_active;
  logic [31:0] s_addr;
  logic [8:0]  s_n, s_i;
  logic [31:0] ar_addr_q[$];
  logic [7:0]  ar_len_q[$];

  assign arready = arready_en;
  assign rid     = 1'b0;
  assign rvalid  = s_active;
  assign rdata   = s_addr + (32'(s_i) << 2);
  assign rlast   = s_active && ((inj_rlast >= 0) ? (int'(s_i) == inj_rlast) : (s_i == s_n - 9'd1));
  assign rresp   = (s_active && int'(s_i) == inj_resp) ? 2'b10 : 2'b00;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_active <= 1'b0;
      s_addr   <= '0;
      s_n      <= '0;
      s_i      <= '0;
    end else if (arvalid && arready) begin
      ar_addr_q.push_back(araddr);
      ar_len_q.push_back(arlen);
      s_active <= 1'b1;
      s_addr   <= araddr;
      s_n      <= 9'(arlen) + 9'd1;
      s_i      <= '0;
    end else if (s_active && rready) begin
      if (s_i == s_n - 9'd1) s_active <= 1'b0;
      else                   s_i <= s_i + 9'd1;
    end
  end

  // Consumer-side monitor
  logic [31:0] beat_q[$];
  int          beat_ch_q[$];
  int          stray = 0;
  int          done_cnt = 0;
  always @(posedge clk) begin
    int s;
    s = 0;
    if (rstn) begin
      for (int c = 0; c < int'(CH); c++) begin
        if (valid[c] && data_next[c]) begin
          beat_q.push_back(data[c*DW +: DW]);
          beat_ch_q.push_back(c);
        end
        if ((valid[c] || data[c*DW +: DW] != '0) && c != exp_ch) s++;
      end
      stray    <= stray + s;
      done_cnt <= done_cnt + (done ? 1 : 0);
    end
  end

  int n_pass = 0, n_total = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(1);
  endtask

  task automatic set_ch(input int c, input logic [31:0] a, input logic [31:0] l);
    address[c*32 +: 32] = a;
    length[c*32 +: 32]  = l;
  endtask

  task automatic kick(input logic [CH-1:0] r);
    router = r;
    start  = 1'b1;
    tick(1);
    start  = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (busy && n < max) begin
      tick(1);
      n++;
    end
    chk(tag, 64'(busy), 64'd0);
  endtask

  task automatic wait_arvalid(input string tag);
    int n = 0;
    while (!arvalid && n < 20) begin
      tick(1);
      n++;
    end
    chk(tag, 64'(arvalid), 64'd1);
  endtask

  task automatic check_beats(input string tag, input int base, input int ch,
                             input logic [31:0] a, input int len);
    int bad = 0;
    chk({tag, "_count"}, 64'(beat_q.size() - base), 64'(len));
    if (beat_q.size() - base == len) begin
      for (int k = 0; k < len; k++)
        if (beat_q[base+k] !== a + 32'(4*k) || beat_ch_q[base+k] != ch) bad++;
    end
    chk({tag, "_data"}, 64'(bad), 64'd0);
  endtask

  int ab, bb, db, sb;

  initial begin
    rstn = 1'b0; start = 1'b0; clear = 1'b0; router = '0;
    address = '0; length = '0; next_v = '1; toggle_en = 1'b0;
    arready_en = 1'b1; inj_rlast = -1; inj_resp = -1; exp_ch = 0;
    tick(2);
    chk("rst_status", {busy, done, error, etype}, 64'd0);
    chk("rst_ar_r", {arvalid, rready}, 64'd0);
    chk("rst_ch_out", {valid, data}, 64'd0);
    chk("arsize", 64'(arsize), 64'd2);
    chk("arburst", 64'(arburst), 64'd1);
    chk("arcache", 64'(arcache), 64'd2);
    chk("ar_misc", {arid, arlock, arprot, arqos}, 64'd0);
    rstn = 1'b1;
    tick(1);

    // Single 4-beat burst on channel 1
    set_ch(0, 32'h5000, 32'd9); set_ch(1, 32'h1000, 32'd4); set_ch(2, 32'h7000, 32'd2);
    exp_ch = 1; ab = ar_addr_q.size(); bb = beat_q.size(); db = done_cnt; sb = stray;
    kick(4'b0010);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_idle("t1_end", 200);
    chk("t1_ar_cnt", 64'(ar_addr_q.size() - ab), 64'd1);
    chk("t1_ar0", {ar_addr_q[ab], ar_len_q[ab]}, {32'h1000, 8'd3});
    check_beats("t1_beats", bb, 1, 32'h1000, 4);
    chk("t1_done", 64'(done_cnt - db), 64'd1);
    chk("t1_stray", 64'(stray - sb), 64'd0);
    chk("t1_err", {error, etype}, 64'd0);

    // 4 KB boundary split
    set_ch(0, 32'h0FF8, 32'd8);
    exp_ch = 0; ab = ar_addr_q.size(); bb = beat_q.size();
    kick(4'b0001);
    wait_idle("t2_end", 200);
    chk("t2_ar_cnt", 64'(ar_addr_q.size() - ab), 64'd2);
    chk("t2_ar0", {ar_addr_q[ab], ar_len_q[ab]}, {32'h0FF8, 8'd1});
    chk("t2_ar1", {ar_addr_q[ab+1], ar_len_q[ab+1]}, {32'h1000, 8'd5});
    check_beats("t2_beats", bb, 0, 32'h0FF8, 8);

    // 600 beats with a toggling consumer; inputs change and start re-pulses mid-transfer
    set_ch(2, 32'h2000, 32'd600);
    exp_ch = 2; ab = ar_addr_q.size(); bb = beat_q.size(); db = done_cnt; sb = stray;
    toggle_en = 1'b1;
    kick(4'b0100);
    set_ch(2, 32'h9000, 32'd5);
    kick(4'b0001);
    wait_idle("t3_end", 5000);
    toggle_en = 1'b0;
    tick(5);
    chk("t3_ar_cnt", 64'(ar_addr_q.size() - ab), 64'd3);
    chk("t3_ar0", {ar_addr_q[ab], ar_len_q[ab]}, {32'h2000, 8'd255});
    chk("t3_ar1", {ar_addr_q[ab+1], ar_len_q[ab+1]}, {32'h2400, 8'd255});
    chk("t3_ar2", {ar_addr_q[ab+2], ar_len_q[ab+2]}, {32'h2800, 8'd87});
    check_beats("t3_beats", bb, 2, 32'h2000, 600);
    chk("t3_done", 64'(done_cnt - db), 64'd1);
    chk("t3_stray", 64'(stray - sb), 64'd0);

    // Multi-hot router, sticky error, clear with start ignored
    kick(4'b0011);
    chk("t4_err", {busy, error, etype}, {1'b0, 1'b1, 3'b001});
    tick(3);
    chk("t4_sticky", {error, etype}, {1'b1, 3'b001});
    clear = 1'b1; start = 1'b1; router = 4'b0001;
    tick(1);
    clear = 1'b0; start = 1'b0;
    chk("t4_clear", {busy, error, etype}, 64'd0);
    tick(1);
    chk("t4_start_ign", 64'(busy), 64'd0);
    kick(4'b0000);
    chk("t4_zero", {error, etype}, {1'b1, 3'b001});
    do_clear();

    // Misaligned address and zero length
    set_ch(0, 32'h1002, 32'd4);
    kick(4'b0001);
    wait_idle("t5_end", 20);
    chk("t5_align", {error, etype}, {1'b1, 3'b010});
    do_clear();
    set_ch(0, 32'h1000, 32'd0);
    kick(4'b0001);
    wait_idle("t5b_end", 20);
    chk("t5_len0", {error, etype}, {1'b1, 3'b010});
    do_clear();

    // Early RLAST
    set_ch(3, 32'h4000, 32'd4); exp_ch = 3; inj_rlast = 1;
    kick(4'b1000);
    wait_idle("t6_end", 50);
    chk("t6_rlast", {error, etype}, {1'b1, 3'b101});
    do_reset();
    inj_rlast = -1;
    chk("t6_rst", {busy, error, etype}, 64'd0);

    // Error response
    inj_resp = 2;
    kick(4'b1000);
    wait_idle("t7_end", 50);
    chk("t7_rresp", {error, etype}, {1'b1, 3'b110});
    do_reset();
    inj_resp = -1;

    // AR watchdog expires after exactly 2^(TO_W-1) waiting cycles
    set_ch(0, 32'h1000, 32'd4); exp_ch = 0; arready_en = 1'b0;
    kick(4'b0001);
    wait_arvalid("t8_arvalid");
    tick(127);
    chk("t8_pre", {busy, error}, 2'b10);
    tick(1);
    chk("t8_to", {error, etype}, {1'b1, 3'b011});
    do_reset();

    // Handshake on the expiry cycle wins
    bb = beat_q.size();
    kick(4'b0001);
    wait_arvalid("t10_arvalid");
    tick(127);
    arready_en = 1'b1;
    wait_idle("t10_end", 100);
    chk("t10_noerr", {error, etype}, 64'd0);
    check_beats("t10_beats", bb, 0, 32'h1000, 4);

    // R watchdog with consumer never ready
    next_v = '0;
    kick(4'b0001);
    wait_idle("t9_end", 400);
    chk("t9_to", {error, etype}, {1'b1, 3'b100});
    next_v = '1;
    do_reset();

    // Asynchronous reset mid-burst, then a clean transfer
    set_ch(1, 32'h1000, 32'd600); exp_ch = 1;
    kick(4'b0010);
    tick(20);
    #2 rstn = 1'b0;
    #1 chk("t11_async", {busy, done, error, etype, arvalid, rready, valid, data}, 64'd0);
    tick(1);
    rstn = 1'b1;
    tick(1);
    set_ch(1, 32'h1000, 32'd4);
    bb = beat_q.size(); db = done_cnt;
    kick(4'b0010);
    wait_idle("t11_end", 200);
    check_beats("t11_beats", bb, 1, 32'h1000, 4);
    chk("t11_done", 64'(done_cnt - db), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/painterengine_gpu_dma_reader_mc.md
PAINTERENGINE_GPU_DMA_READER_MC -- requirements
Module: painterengine_gpu_dma_reader_mc

Interface
REQ-001 SHALL have parameter CH, default 4: number of routed consumer channels, 1..8.
REQ-002 SHALL have parameter DW, default 32: AXI read data width, 32 or 64.
REQ-003 SHALL have parameter MAX_BURST, default 256: maximum beats per AR burst, 1..256.
REQ-004 SHALL have parameter TO_W, default 19: watchdog counter width; timeout fires when bit TO_W-1 sets.
REQ-005 SHALL have port i_wire_clock  in  1  clock, all logic on rising edge.
REQ-006 SHALL have port i_wire_resetn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_wire_start  in  1  start request, sampled in IDLE only.
REQ-008 SHALL have port i_wire_clear  in  1  leaves ERROR and returns to IDLE.
REQ-009 SHALL have port i_wire_router  in  CH  one-hot channel select.
REQ-010 SHALL have port i_wire_address  in  CH*32  per-channel byte start address.
REQ-011 SHALL have port i_wire_length  in  CH*32  per-channel length in DW-wide beats.
REQ-012 SHALL have port o_wire_data  out  CH*DW  per-channel read data.
REQ-013 SHALL have port o_wire_data_valid  out  CH  per-channel data valid.
REQ-014 SHALL have port i_wire_data_next  in  CH  per-channel consumer ready.
REQ-015 SHALL have ports o_wire_busy, o_wire_done, o_wire_error  out  1 each: status.
REQ-016 SHALL have port o_wire_error_type  out  3  error code.
REQ-017 SHALL have AR ports o_wire_M_AXI_ARADDR out 32, ARLEN out 8, ARVALID out 1, and i_wire_M_AXI_ARREADY in 1.
REQ-018 SHALL drive constant AR sideband outputs: ARID out 1 = 0, ARSIZE out 3 = log2(DW/8), ARBURST out 2 = INCR, ARLOCK out 1 = 0, ARCACHE out 4 = 0010, ARPROT out 3 = 0, ARQOS out 4 = 0.
REQ-019 SHALL have R ports i_wire_M_AXI_RID in 1, RDATA in DW, RRESP in 2, RLAST in 1, RVALID in 1, and o_wire_M_AXI_RREADY out 1.

Function
REQ-020 SHALL implement FSM states IDLE, CHECK, CALC, ADDR, DATA, DONE and ERROR; o_wire_busy is high in every state except IDLE and ERROR.
REQ-021 IDLE + start SHALL latch address, length and channel index of the router bit; router zero, multi-hot, or bit >= CH -> ERROR, type 001; otherwise -> CHECK.
REQ-022 CHECK SHALL raise ERROR type 010 if address is not DW/8-aligned or length == 0; otherwise clear offset and watchdog -> CALC.
REQ-023 CALC SHALL compute burst = min(MAX_BURST, length-offset, beats to next 4 KB boundary of address+offset*(DW/8)) -> ADDR.
REQ-024 ADDR SHALL drive ARADDR = address+offset*(DW/8) mod 2^32 and ARLEN = burst-1, both stable while ARVALID is high; on ARREADY, drop ARVALID next cycle -> DATA.
REQ-025 RREADY SHALL equal i_wire_data_next[idx] in DATA and 0 otherwise; a beat is accepted when RVALID && RREADY.
REQ-026 o_wire_data[idx] / o_wire_data_valid[idx] SHALL carry RDATA / RVALID in DATA only; all other channels and states output 0.
REQ-027 The accepted beat with counter == burst-1 SHALL carry RLAST; missing or early RLAST -> ERROR, type 101.
REQ-028 Any accepted beat with RRESP != 00 SHALL go to ERROR, type 110.
REQ-029 After the last beat, offset += burst; offset >= length -> DONE, else -> CALC.
REQ-030 DONE SHALL assert o_wire_done for exactly one cycle with type 000, then -> IDLE.
REQ-031 The watchdog SHALL increment on each waiting cycle in ADDR/DATA and clear on each handshake; MSB set -> ERROR with type 011 (ADDR) or 100 (DATA). A handshake in the same cycle as the MSB set takes priority.
REQ-032 ERROR SHALL be sticky, with o_wire_error high and the type held, until i_wire_clear -> IDLE with type 000; start in the same cycle is ignored.
REQ-033 start while busy SHALL be ignored; address, length and router changes after latching SHALL have no effect.

Reset
REQ-034 On reset assertion, the block SHALL enter IDLE immediately, including mid-burst, and drive ARVALID, RREADY, data, valid, busy, done and error to 0, error type to 000, and all counters to 0.

Verification
REQ-035 ch1, addr 0x1000, len 4, ARREADY and RVALID always high -> one AR with ARLEN 3; 4 beats on channel 1 only; done pulses 1 cycle.
REQ-036 addr 0x0FF8, len 8, DW 32 -> ARs at 0x0FF8 with ARLEN 1 and 0x1000 with ARLEN 5 (4 KB split).
REQ-037 len 600 -> bursts of 256, 256 and 88 beats; data_next toggling -> no beats lost or duplicated.
REQ-038 router 0b0011 -> error type 001; addr 0x1002 -> error type 010; clear -> IDLE.
REQ-039 RLAST asserted on beat 2 of 4 -> type 101; RRESP 10 -> type 110; ARREADY held low 2^(TO_W-1) cycles -> type 011.
